// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter onto four openRam byte lanes
module ram_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int RAM_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic                                CTRL_CSb1,
    input  logic                                CTRL_WEb1,
    input  logic [ADDR_W-1:0]                   CTRL_ADDR1,
    input  logic [DATA_W-1:0]                   CTRL_DATA_IN1,
    output logic [DATA_W-1:0]                   CTRL_DATA_OUT1,
    output logic                                CTRL_ACK1,
    input  logic                                CTRL_CSb2,
    input  logic                                CTRL_WEb2,
    input  logic [ADDR_W-1:0]                   CTRL_ADDR2,
    input  logic [DATA_W-1:0]                   CTRL_DATA_IN2,
    output logic [DATA_W-1:0]                   CTRL_DATA_OUT2,
    output logic                                CTRL_ACK2,
    output logic [DATA_W/8-1:0]                 RAM_CSb,
    output logic [DATA_W/8-1:0]                 RAM_WEb,
    output logic [(DATA_W/8)*RAM_ADDR_W-1:0]    RAM_ADDR,
    output logic [DATA_W-1:0]                   RAM_DATA_IN,
    input  logic [DATA_W-1:0]                   RAM_DATA_OUT
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  req1;
    logic                  req2;
    logic                  grant_nxt;
    logic                  take_req;
    logic [ADDR_W-1:0]     sel_addr;
    logic                  unused_addr_lsbs;

    logic                  grant_q;
    logic                  last_grant2_q;
    logic                  web_q;
    logic                  oor_q;
    logic [RAM_ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;

    assign req1 = !CTRL_CSb1;
    assign req2 = !CTRL_CSb2;

    // grant_nxt = 1 selects requester 2; on a tie the one not served last wins
    assign grant_nxt = (req1 && req2) ? !last_grant2_q : req2;
    assign take_req  = (state == S_IDLE) && (req1 || req2);
    assign sel_addr  = grant_nxt ? CTRL_ADDR2 : CTRL_ADDR1;

    // byte offset within the word has no meaning for whole-word accesses
    assign unused_addr_lsbs = ^sel_addr[1:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req1 || req2) state_nxt = S_ACCESS;
            S_ACCESS:  state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            grant_q       <= 1'b0;
            last_grant2_q <= 1'b1;
            web_q         <= 1'b1;
            oor_q         <= 1'b0;
            idx_q         <= '0;
            wdata_q       <= '0;
        end else if (take_req) begin
            grant_q       <= grant_nxt;
            last_grant2_q <= grant_nxt;
            web_q         <= grant_nxt ? CTRL_WEb2 : CTRL_WEb1;
            oor_q         <= |sel_addr[ADDR_W-1:RAM_ADDR_W+2];
            idx_q         <= sel_addr[RAM_ADDR_W+1:2];
            wdata_q       <= grant_nxt ? CTRL_DATA_IN2 : CTRL_DATA_IN1;
        end
    end

    // RAM output is valid during CAPTURE, one cycle after the lanes sampled
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            CTRL_DATA_OUT1 <= '0;
            CTRL_DATA_OUT2 <= '0;
        end else if (state == S_CAPTURE && web_q) begin
            if (grant_q) begin
                CTRL_DATA_OUT2 <= oor_q ? '0 : RAM_DATA_OUT;
            end else begin
                CTRL_DATA_OUT1 <= oor_q ? '0 : RAM_DATA_OUT;
            end
        end
    end

    always_comb begin
        RAM_CSb   = '1;
        RAM_WEb   = '1;
        CTRL_ACK1 = 1'b0;
        CTRL_ACK2 = 1'b0;
        case (state)
            S_ACCESS: begin
                if (!oor_q) begin
                    RAM_CSb = '0;
                    RAM_WEb = {LANES{web_q}};
                end
            end
            S_DONE: begin
                CTRL_ACK1 = !grant_q;
                CTRL_ACK2 = grant_q;
            end
            default: begin
                RAM_CSb = '1;
            end
        endcase
    end

    assign RAM_ADDR    = {LANES{idx_q}};
    assign RAM_DATA_IN = wdata_q;

endmodule
